// File: rtl/segmentation_pkg.sv
// Shared types and constants for the descriptor table responder.
package segmentation_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESPOND
  } state_e;

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned WORD_W = 32;

  // Legal when word aligned and the word index falls inside the store.
  function automatic logic addr_legal(input logic [WORD_W-1:0] offset,
                                      input int unsigned        depth);
    return (offset[1:0] == 2'b00) && ((offset >> 2) < depth);
  endfunction

endpackage

// File: rtl/descriptor_ram.sv
// Descriptor store: one synchronous read port, one write port, read-before-write.
module descriptor_ram #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Non-blocking update gives old data on a same-word read/write collision.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_data_o <= mem_q[rd_addr_i];
    end
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/descriptor_table_responder.sv
// Wait-stated read responder over a loadable descriptor table, with one
// pending-request slot and a sticky overrun flag for dropped requests.
module descriptor_table_responder
  import segmentation_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 256,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int unsigned WAIT_STATES  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] bus_read_address,
  input  logic              bus_vaild,
  output logic [WORD_W-1:0] bus_read_data,
  output logic              bus_ready,
  output logic              bus_error,
  input  logic              write_valid,
  input  logic [WORD_W-1:0] write_address,
  input  logic [WORD_W-1:0] write_data,
  output logic              busy,
  output logic              overrun,
  input  logic              overrun_clear
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

  state_e              state_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [WORD_W-1:0]   addr_q;
  logic [WORD_W-1:0]   pend_addr_q;
  logic                pend_valid_q;
  logic                ready_q;
  logic                error_q;
  logic                overrun_q;

  logic [WORD_W-1:0]   rd_offset_d;
  logic                rd_legal_d;
  logic                rd_en_d;
  logic [WORD_W-1:0]   wr_offset_d;
  logic                wr_legal_d;
  logic [WORD_W-1:0]   ram_rdata;

  always_comb begin
    rd_offset_d = addr_q - BASE_ADDRESS;
    rd_legal_d  = addr_legal(rd_offset_d, DEPTH_WORDS);
    rd_en_d     = (state_q == ST_WAIT) && (wait_cnt_q == '0) && rd_legal_d;
    wr_offset_d = write_address - BASE_ADDRESS;
    wr_legal_d  = write_valid && addr_legal(wr_offset_d, DEPTH_WORDS);
  end

  descriptor_ram #(
    .DEPTH  (DEPTH_WORDS),
    .ADDR_W (IDX_W),
    .DATA_W (WORD_W)
  ) u_ram (
    .clk_i     (clock),
    .rd_en_i   (rd_en_d),
    .rd_addr_i (rd_offset_d[IDX_W+1:2]),
    .rd_data_o (ram_rdata),
    .wr_en_i   (wr_legal_d),
    .wr_addr_i (wr_offset_d[IDX_W+1:2]),
    .wr_data_i (write_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      addr_q       <= '0;
      pend_addr_q  <= '0;
      pend_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      if (overrun_clear) begin
        overrun_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus_vaild) begin
            addr_q     <= bus_read_address;
            wait_cnt_q <= WAIT_INIT;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A set later in this block overrides a coincident clear.
          if (bus_vaild) begin
            if (!pend_valid_q) begin
              pend_valid_q <= 1'b1;
              pend_addr_q  <= bus_read_address;
            end else begin
              overrun_q <= 1'b1;
            end
          end
          if (wait_cnt_q == '0) begin
            state_q <= ST_RESPOND;
            ready_q <= 1'b1;
            error_q <= !rd_legal_d;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        ST_RESPOND: begin
          if (pend_valid_q) begin
            addr_q     <= pend_addr_q;
            wait_cnt_q <= WAIT_INIT;
            state_q    <= ST_WAIT;
            if (bus_vaild) begin
              pend_addr_q <= bus_read_address;
            end else begin
              pend_valid_q <= 1'b0;
            end
          end else if (bus_vaild) begin
            addr_q     <= bus_read_address;
            wait_cnt_q <= WAIT_INIT;
            state_q    <= ST_WAIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // RAM output is unreset and stale between reads, so it is gated here.
  assign bus_read_data = (ready_q && !error_q) ? ram_rdata : '0;
  assign bus_ready     = ready_q;
  assign bus_error     = error_q;
  assign busy          = (state_q != ST_IDLE) || pend_valid_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_descriptor_table_responder.sv
// Directed self-checking bench for descriptor_table_responder (default parameters).
module tb_descriptor_table_responder;

  logic        clock;
  logic        reset;
  logic [31:0] bus_read_address;
  logic        bus_vaild;
  logic [31:0] bus_read_data;
  logic        bus_ready;
  logic        bus_error;
  logic        write_valid;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic        busy;
  logic        overrun;
  logic        overrun_clear;

  int errors = 0;
  int checks = 0;

  descriptor_table_responder #(
    .DEPTH_WORDS  (256),
    .BASE_ADDRESS (32'h0000_0000),
    .WAIT_STATES  (2)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .bus_read_address (bus_read_address),
    .bus_vaild        (bus_vaild),
    .bus_read_data    (bus_read_data),
    .bus_ready        (bus_ready),
    .bus_error        (bus_error),
    .write_valid      (write_valid),
    .write_address    (write_address),
    .write_data       (write_data),
    .busy             (busy),
    .overrun          (overrun),
    .overrun_clear    (overrun_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    write_valid   = 1'b1;
    write_address = a;
    write_data    = d;
    tick();
    write_valid   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus_ready); end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", bus_error); end
    checks++; if (bus_read_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus_read_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    write_word(32'h00, 32'h1234_5678);
    write_word(32'h08, 32'h0000_FFFF);
    write_word(32'h0C, 32'h00CF_9A00);
    bus_vaild = 1'b1; bus_read_address = 32'h08;
    tick();
    bus_vaild = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    tick(); tick();
    checks++; if (bus_ready !== 1'b0) begin errors++; $display("FAIL single_early: ready got %b want 0 at T+3", bus_ready); end
    tick();
    checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1 at T+4", bus_ready); end
    checks++; if (bus_read_data !== 32'h0000_FFFF) begin errors++; $display("FAIL single_data: got %h want 0000ffff", bus_read_data); end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL single_error: got %b want 0", bus_error); end
    tick();
    checks++; if (bus_ready !== 1'b0) begin errors++; $display("FAIL single_oneshot: ready got %b want 0", bus_ready); end
    checks++; if (bus_read_data !== 32'h0) begin errors++; $display("FAIL single_data_idle: got %h want 0", bus_read_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    bus_vaild = 1'b1; bus_read_address = 32'h08;
    tick();
    bus_read_address = 32'h0C;
    tick();
    bus_vaild = 1'b0;
    tick(); tick();
    checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b want 1 at T+4", bus_ready); end
    checks++; if (bus_read_data !== 32'h0000_FFFF) begin errors++; $display("FAIL b2b_data1: got %h want 0000ffff", bus_read_data); end
    tick(); tick(); tick();
    checks++; if (bus_ready !== 1'b0) begin errors++; $display("FAIL b2b_gap: ready got %b want 0 at T+7", bus_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1 at T+7", busy); end
    tick();
    checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2: got %b want 1 at T+8", bus_ready); end
    checks++; if (bus_read_data !== 32'h00CF_9A00) begin errors++; $display("FAIL b2b_data2: got %h want 00cf9a00", bus_read_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_busy: got %b want 0", busy); end
  endtask

  task automatic test_overrun();
    int n;
    bus_vaild = 1'b1; bus_read_address = 32'h08;
    tick();
    bus_read_address = 32'h0C;
    tick();
    bus_read_address = 32'h00;
    tick();
    bus_vaild = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1 at T+3", overrun); end
    n = 0;
    for (int i = 4; i <= 12; i++) begin
      tick();
      if (bus_ready === 1'b1) n++;
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL ovr_count: got %0d responses want 2", n); end
    overrun_clear = 1'b1;
    tick();
    overrun_clear = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    // set and clear in the same cycle: set must win
    bus_vaild = 1'b1; bus_read_address = 32'h08;
    tick();
    tick();
    overrun_clear = 1'b1;
    tick();
    bus_vaild = 1'b0; overrun_clear = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_setwins: got %b want 1", overrun); end
    for (int i = 0; i < 10; i++) tick();
    overrun_clear = 1'b1;
    tick();
    overrun_clear = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_drain_busy: got %b want 0", busy); end
  endtask

  task automatic test_illegal();
    bus_vaild = 1'b1; bus_read_address = 32'h0A;
    tick();
    bus_vaild = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL mis_ready: got %b want 1", bus_ready); end
    checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL mis_error: got %b want 1", bus_error); end
    checks++; if (bus_read_data !== 32'h0) begin errors++; $display("FAIL mis_data: got %h want 0", bus_read_data); end
    tick();
    write_word(32'h400, 32'hBAD0_BAD0);
    bus_vaild = 1'b1; bus_read_address = 32'h400;
    tick();
    bus_vaild = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL oor_ready: got %b want 1", bus_ready); end
    checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL oor_error: got %b want 1", bus_error); end
    checks++; if (bus_read_data !== 32'h0) begin errors++; $display("FAIL oor_data: got %h want 0", bus_read_data); end
    tick();
    bus_vaild = 1'b1; bus_read_address = 32'h00;
    tick();
    bus_vaild = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus_read_data !== 32'h1234_5678) begin errors++; $display("FAIL oor_nowrap: word0 got %h want 12345678", bus_read_data); end
    tick();
  endtask

  task automatic test_read_before_write();
    bus_vaild = 1'b1; bus_read_address = 32'h08;
    tick();
    bus_vaild = 1'b0;
    tick(); tick();
    write_word(32'h08, 32'hDEAD_BEEF);
    checks++; if (bus_read_data !== 32'h0000_FFFF) begin errors++; $display("FAIL rbw_old: got %h want 0000ffff", bus_read_data); end
    tick();
    bus_vaild = 1'b1; bus_read_address = 32'h08;
    tick();
    bus_vaild = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus_read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rbw_new: got %h want deadbeef", bus_read_data); end
    tick();
  endtask

  task automatic test_reset_midflight();
    int n;
    bus_vaild = 1'b1; bus_read_address = 32'h0C;
    tick();
    bus_vaild = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0 at T+3", busy); end
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus_ready === 1'b1) n++;
      tick();
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL rst_noresp: got %0d responses want 0", n); end
    bus_vaild = 1'b1; bus_read_address = 32'h0C;
    tick();
    bus_vaild = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL rst_after_ready: got %b want 1", bus_ready); end
    checks++; if (bus_read_data !== 32'h00CF_9A00) begin errors++; $display("FAIL rst_after_data: got %h want 00cf9a00", bus_read_data); end
    tick();
  endtask

  initial begin
    reset            = 1'b1;
    bus_vaild        = 1'b0;
    bus_read_address = '0;
    write_valid      = 1'b0;
    write_address    = '0;
    write_data       = '0;
    overrun_clear    = 1'b0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_overrun();
    test_illegal();
    test_read_before_write();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/descriptor_table_responder.md
DESCRIPTOR_TABLE_RESPONDER -- requirements
Module: descriptor_table_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning number of 32-bit words in the descriptor store (power of two).
REQ-002 SHALL have parameter BASE_ADDRESS, default 32'h0000_0000, meaning the linear address of word 0.
REQ-003 SHALL have parameter WAIT_STATES, default 2, meaning extra cycles inserted before each response (0..15).
REQ-004 clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 bus_read_address  input  32  linear byte address of the requested descriptor word.
REQ-007 bus_vaild  input  1  one-cycle request strobe; address is sampled in the same cycle.
REQ-008 bus_read_data  output  32  response data; valid only while bus_ready=1.
REQ-009 bus_ready  output  1  one-cycle response strobe.
REQ-010 bus_error  output  1  qualifies bus_ready: the request was misaligned or out of range.
REQ-011 write_valid  input  1  table-load strobe.
REQ-012 write_address  input  32  byte address of the word to load.
REQ-013 write_data  input  32  word to load.
REQ-014 busy  output  1  high while a request is in flight or pending.
REQ-015 overrun  output  1  sticky flag: a request was dropped.
REQ-016 overrun_clear  input  1  clears overrun.

Function
REQ-017 SHALL decode index = (address - BASE_ADDRESS) >> 2; a request is legal only if address[1:0]=0 and index < DEPTH_WORDS.
REQ-018 SHALL implement FSM states IDLE, WAIT, RESPOND.
REQ-019 IDLE: on bus_vaild, capture the address and go to WAIT with wait_count=WAIT_STATES; if WAIT_STATES=0, go to WAIT for one cycle only.
REQ-020 WAIT: decrement wait_count each cycle; at 0, read the store (registered) and go to RESPOND.
REQ-021 RESPOND: assert bus_ready for exactly one cycle with bus_read_data and bus_error.
  - Legal request: bus_read_data = store[index], bus_error=0.
  - Illegal request: bus_read_data = 0, bus_error=1.
REQ-022 Latency SHALL be exactly WAIT_STATES+2 cycles from the bus_vaild cycle to the bus_ready cycle (default: 4).
REQ-023 SHALL hold one pending request: bus_vaild while not IDLE and pending empty -> address stored in pending.
REQ-024 In RESPOND, with pending full, SHALL start the pending request (go to WAIT) without passing through IDLE; a bus_vaild in that same cycle fills the freed pending slot.
REQ-025 In RESPOND, with pending empty, a bus_vaild in that cycle SHALL start directly as in IDLE.
REQ-026 bus_vaild arriving when pending is full and not freed that cycle SHALL be dropped: set overrun, emit no response.
REQ-027 Overrun: overrun_clear clears it; if set and clear coincide, set wins.
REQ-028 write_valid SHALL update store[index] at the clock edge when the address is legal; illegal writes are ignored silently.
REQ-029 A write and a read of the same word in the same cycle SHALL return old data (read-before-write); later reads return new data.
REQ-030 Writes SHALL never stall or affect FSM timing.
REQ-031 busy = (state != IDLE) | pending_valid.
REQ-032 Outside RESPOND: bus_ready=0, bus_error=0, bus_read_data=0.

Reset
REQ-033 Reset SHALL force state=IDLE, wait_count=0, pending empty, bus_ready=0, bus_error=0, bus_read_data=0, busy=0, overrun=0.
REQ-034 Reset mid-operation SHALL abandon in-flight and pending requests with no bus_ready emitted.
REQ-035 Reset SHALL not clear store contents; they are undefined until written.

Structure
REQ-036 The FSM state enum, WAIT_STATES width constant and descriptor word size constant SHALL live in a shared package, segmentation_pkg.
REQ-037 The store SHALL be a sub-module descriptor_ram: 1 sync read port, 1 write port, read-before-write.

Verification
REQ-038 Load word 0x08=32'h0000_FFFF and 0x0C=32'h00CF_9A00; bus_vaild at T with 0x08 -> bus_ready at T+4, data 0000_FFFF, bus_error=0.
REQ-039 bus_vaild 0x08 at T and 0x0C at T+1 -> responses at T+4 (0000_FFFF) and T+8 (00CF_9A00); overrun=0.
REQ-040 Three bus_vaild strobes at T, T+1, T+2 -> exactly two responses; overrun=1 from T+3; overrun_clear -> 0.
REQ-041 Request at 0x0A (misaligned) and at 0x400 (index 256) -> bus_ready with bus_error=1, data 0; a write to 0x400 is ignored.
REQ-042 Write 32'hDEAD_BEEF to 0x08 in the cycle the store read of 0x08 occurs -> response returns old 0000_FFFF; next read returns DEAD_BEEF.
REQ-043 Assert reset at T+2 of an in-flight request -> no bus_ready; busy=0 at T+3; a new request afterwards completes in 4 cycles.
